// File: rtl/penc_pkg.sv
// ----------------------------------------------------------------------------
// penc_pkg
// Shared types and helpers for the priority scan encoder.
//   penc_state_e : scan FSM state encoding (PENC_IDLE, PENC_SCAN)
//   penc_idx_w   : index width for a request vector of a given width
// ----------------------------------------------------------------------------
package penc_pkg;

   typedef enum logic [0:0] {
      PENC_IDLE = 1'b0,
      PENC_SCAN = 1'b1
   } penc_state_e;

   // Keep at least one index bit, so a degenerate width still gives a legal port.
   function automatic int penc_idx_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/penc_find_first.sv
// ----------------------------------------------------------------------------
// penc_find_first
// Purely combinational first-set-bit finder.
// Optional build macro: PENC_LSB_FIRST_EN
//   undefined : bit WIDTH-1 has the highest priority (MSB first)
//   defined   : bit 0 has the highest priority (LSB first)
// Ports:
//   i_vec : WIDTH-bit vector to search
//   o_idx : index of the highest-priority set bit (0 when i_vec is zero)
//   o_one : high when exactly one bit of i_vec is set
// ----------------------------------------------------------------------------
module penc_find_first
   import penc_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int IDX_W = penc_idx_w(WIDTH)
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_one
);

   logic [IDX_W-1:0] w_idx;

   // Priority search: the last matching bit visited by the loop wins, so the
   // loop walks from lowest to highest priority.
   always_comb begin
      w_idx = {IDX_W{1'b0}};
`ifdef PENC_LSB_FIRST_EN
      for (int i = WIDTH - 1; i >= 0; i--) begin
         w_idx = i_vec[i] ? IDX_W'(i) : w_idx;
      end
`else
      for (int i = 0; i < WIDTH; i++) begin
         w_idx = i_vec[i] ? IDX_W'(i) : w_idx;
      end
`endif
   end

   assign o_idx = w_idx;

   // v & (v-1) strips the lowest set bit; nothing left means exactly one was set.
   assign o_one = (i_vec != {WIDTH{1'b0}}) &&
                  ((i_vec & (i_vec - WIDTH'(1))) == {WIDTH{1'b0}});

endmodule

// File: rtl/priority_scan_encoder.sv
// ----------------------------------------------------------------------------
// priority_scan_encoder
// Captures a WIDTH-bit request vector and emits the index of every set bit,
// one per accepted output beat, in priority order. The last index of a vector
// is flagged with out_last. An all-zero vector produces only empty_pulse.
// Optional build macro: PENC_LSB_FIRST_EN (LSB-first scan order, see
// penc_find_first); handshake and timing are identical in both builds.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request vector handshake, in_data is the vector
//   out_valid/out_ready : index handshake, out_idx/out_last are the payload
//   empty_pulse         : one-cycle pulse after an all-zero vector is accepted
//   busy                : high while a vector is being scanned
// ----------------------------------------------------------------------------
module priority_scan_encoder
   import penc_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int IDX_W = penc_idx_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             empty_pulse,
   output logic             busy
);

   penc_state_e      r_state;
   penc_state_e      w_state_nxt;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] w_work_nxt;
   logic [WIDTH-1:0] w_clr_mask;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_ff_idx;
   logic             r_last;
   logic             w_ff_one;
   logic             r_empty;
   logic             w_empty_nxt;

   assign w_clr_mask = WIDTH'(1) << r_idx;

   // The finder looks at the next work value so that out_idx/out_last can be
   // registered alongside the work register and change only on a clock edge.
   penc_find_first #(
      .WIDTH (WIDTH)
   ) u_find (
      .i_vec (w_work_nxt),
      .o_idx (w_ff_idx),
      .o_one (w_ff_one)
   );

   // Next-state logic: load on accept, clear the emitted bit on each beat.
   always_comb begin
      w_state_nxt = r_state;
      w_work_nxt  = r_work;
      w_empty_nxt = 1'b0;
      case (r_state)
         PENC_IDLE: begin
            if (in_valid) begin
               if (in_data != {WIDTH{1'b0}}) begin
                  w_work_nxt  = in_data;
                  w_state_nxt = PENC_SCAN;
               end else begin
                  w_empty_nxt = 1'b1;
               end
            end else begin
               w_state_nxt = PENC_IDLE;
            end
         end
         PENC_SCAN: begin
            if (out_ready) begin
               // The final beat clears the last bit, leaving the work register zero.
               w_work_nxt  = r_work & ~w_clr_mask;
               w_state_nxt = r_last ? PENC_IDLE : PENC_SCAN;
            end else begin
               w_state_nxt = PENC_SCAN;
            end
         end
         default: begin
            w_state_nxt = PENC_IDLE;
            w_work_nxt  = {WIDTH{1'b0}};
         end
      endcase
   end

   // State, work register and registered output payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= PENC_IDLE;
         r_work  <= {WIDTH{1'b0}};
         r_idx   <= {IDX_W{1'b0}};
         r_last  <= 1'b0;
         r_empty <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_work  <= w_work_nxt;
         r_idx   <= w_ff_idx;
         r_last  <= w_ff_one;
         r_empty <= w_empty_nxt;
      end
   end

   assign in_ready    = (r_state == PENC_IDLE);
   assign out_valid   = (r_state == PENC_SCAN);
   assign busy        = (r_state == PENC_SCAN);
   assign out_idx     = r_idx;
   assign out_last    = r_last;
   assign empty_pulse = r_empty;

endmodule
